// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if -- issue / writeback / status bundle for reg_scoreboard.
//
// Signals:
//   issue side     : issue_valid, issue_ready, sr1/sr1_needed, sr2/sr2_needed,
//                    de_br_op, issue_ld_reg, issue_dr, issue_ld_cc
//   writeback side : wb_valid, wb_ld_reg, wb_dr, wb_ld_cc
//   control        : flush
//   status         : dep_stall, reg_busy[7:0], cc_busy, sb_err
// Modports:
//   master : decode/writeback driver (drives requests, observes status)
//   slave  : the scoreboard itself
interface reg_scoreboard_if;
  logic       issue_valid;
  logic       issue_ready;
  logic [2:0] sr1;
  logic       sr1_needed;
  logic [2:0] sr2;
  logic       sr2_needed;
  logic       de_br_op;
  logic       issue_ld_reg;
  logic [2:0] issue_dr;
  logic       issue_ld_cc;
  logic       wb_valid;
  logic       wb_ld_reg;
  logic [2:0] wb_dr;
  logic       wb_ld_cc;
  logic       flush;
  logic       dep_stall;
  logic [7:0] reg_busy;
  logic       cc_busy;
  logic       sb_err;

  modport master (
    output issue_valid, sr1, sr1_needed, sr2, sr2_needed, de_br_op,
           issue_ld_reg, issue_dr, issue_ld_cc,
           wb_valid, wb_ld_reg, wb_dr, wb_ld_cc, flush,
    input  issue_ready, dep_stall, reg_busy, cc_busy, sb_err
  );

  modport slave (
    input  issue_valid, sr1, sr1_needed, sr2, sr2_needed, de_br_op,
           issue_ld_reg, issue_dr, issue_ld_cc,
           wb_valid, wb_ld_reg, wb_dr, wb_ld_cc, flush,
    output issue_ready, dep_stall, reg_busy, cc_busy, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- register / condition-code scoreboard for an in-order pipe.
//
// Keeps a saturating 2-bit pending-write counter per register R0-R7 plus one
// for the condition codes. Issue increments, writeback decrements, flush
// zeroes everything. A writeback to an idle counter raises the sticky sb_err.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears counters and sb_err)
//   sb      : reg_scoreboard_if.slave bundle (issue, writeback, flush, status)
//
// Build option:
//   SCOREBOARD_BYPASS_EN -- when defined, a source whose counter is 1 and is
//   being written back this same cycle is not treated as a hazard. The
//   reg_busy / cc_busy status outputs always reflect the raw counters.
module reg_scoreboard (
  input  logic            clk,
  input  logic            reset_n,
  reg_scoreboard_if.slave sb
);

  logic [1:0] r_reg_cnt [0:7];
  logic [1:0] r_cc_cnt;
  logic       r_sb_err;

  logic [1:0] w_reg_cnt_nxt [0:7];
  logic [1:0] w_cc_cnt_nxt;
  logic       w_underflow;
  logic [7:0] w_reg_busy;
  logic [7:0] w_wb_hit;
  logic [7:0] w_src_busy;
  logic [7:0] w_issue_hit;
  logic       w_cc_busy;
  logic       w_cc_wb_hit;
  logic       w_cc_src_busy;
  logic       w_cc_issue_hit;
  logic       w_dep_stall;
  logic       w_issue_ready;
  logic       w_issue_acc;

  // Saturating counter step; an increment and a decrement together cancel.
  function automatic logic [1:0] f_step(input logic [1:0] cnt,
                                        input logic       inc,
                                        input logic       dec);
    logic [1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = (cnt == 2'd3) ? cnt : cnt + 2'd1;
      2'b01:   nxt = (cnt == 2'd0) ? cnt : cnt - 2'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  // A lone decrement of an idle counter is an underflow.
  function automatic logic f_underflow(input logic [1:0] cnt,
                                       input logic       inc,
                                       input logic       dec);
    return dec & ~inc & (cnt == 2'd0);
  endfunction

  // Raw busy flags, writeback targets and hazard-visible busy per source.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_reg_busy[i] = (r_reg_cnt[i] != 2'd0);
      w_wb_hit[i]   = sb.wb_valid & sb.wb_ld_reg & (sb.wb_dr == 3'(i));
`ifdef SCOREBOARD_BYPASS_EN
      w_src_busy[i] = w_reg_busy[i] & ~((r_reg_cnt[i] == 2'd1) & w_wb_hit[i]);
`else
      w_src_busy[i] = w_reg_busy[i];
`endif
    end
    w_cc_busy   = (r_cc_cnt != 2'd0);
    w_cc_wb_hit = sb.wb_valid & sb.wb_ld_cc;
`ifdef SCOREBOARD_BYPASS_EN
    w_cc_src_busy = w_cc_busy & ~((r_cc_cnt == 2'd1) & w_cc_wb_hit);
`else
    w_cc_src_busy = w_cc_busy;
`endif
  end

  // Hazard detection and issue handshake; ready never looks at issue_valid.
  always_comb begin
    w_dep_stall   = (sb.sr1_needed & w_src_busy[sb.sr1])
                  | (sb.sr2_needed & w_src_busy[sb.sr2])
                  | (sb.de_br_op   & w_cc_src_busy);
    w_issue_ready = ~w_dep_stall & ~sb.flush
                  & ~(sb.issue_ld_reg & (r_reg_cnt[sb.issue_dr] == 2'd3))
                  & ~(sb.issue_ld_cc  & (r_cc_cnt == 2'd3));
    w_issue_acc   = sb.issue_valid & w_issue_ready;
  end

  // Next counter values and underflow detection (flush is applied in the register).
  always_comb begin
    w_underflow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_issue_hit[i]   = w_issue_acc & sb.issue_ld_reg & (sb.issue_dr == 3'(i));
      w_reg_cnt_nxt[i] = f_step(r_reg_cnt[i], w_issue_hit[i], w_wb_hit[i]);
      w_underflow      = w_underflow | f_underflow(r_reg_cnt[i], w_issue_hit[i], w_wb_hit[i]);
    end
    w_cc_issue_hit = w_issue_acc & sb.issue_ld_cc;
    w_cc_cnt_nxt   = f_step(r_cc_cnt, w_cc_issue_hit, w_cc_wb_hit);
    w_underflow    = w_underflow | f_underflow(r_cc_cnt, w_cc_issue_hit, w_cc_wb_hit);
  end

  // Counter and sticky-error state; flush wins over same-cycle issue/writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_reg_cnt[i] <= 2'd0;
      end
      r_cc_cnt <= 2'd0;
      r_sb_err <= 1'b0;
    end else if (sb.flush) begin
      for (int i = 0; i < 8; i++) begin
        r_reg_cnt[i] <= 2'd0;
      end
      r_cc_cnt <= 2'd0;
      r_sb_err <= r_sb_err;
    end else begin
      for (int i = 0; i < 8; i++) begin
        r_reg_cnt[i] <= w_reg_cnt_nxt[i];
      end
      r_cc_cnt <= w_cc_cnt_nxt;
      r_sb_err <= r_sb_err | w_underflow;
    end
  end

  assign sb.reg_busy    = w_reg_busy;
  assign sb.cc_busy     = w_cc_busy;
  assign sb.dep_stall   = w_dep_stall;
  assign sb.issue_ready = w_issue_ready;
  assign sb.sb_err      = r_sb_err;

endmodule
